// File: rtl/memory_responder_if.sv
// Initiator/responder bundle for the memory responder: request fields in, completion and read data out.
// The initiator holds mov until moc is seen; the responder holds moc until mov drops.
interface memory_responder_if;
  logic        mov;
  logic        rw;
  logic        sig;
  logic [1:0]  dl;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic        moc;
  logic [31:0] data_out;
  logic        err;

  modport master (
    output mov, rw, sig, dl, address, data_in,
    input  moc, data_out, err
  );

  modport slave (
    input  mov, rw, sig, dl, address, data_in,
    output moc, data_out, err
  );
endinterface

// File: rtl/memory_responder.sv
// 512-byte big-endian memory responder; moc rises WAIT_CYCLES+2 cycles after mov is sampled and is held until mov drops.
// Optional MEM_RESP_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with err instead of wrapping.
module memory_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  memory_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        sig_q, sig_d;
  logic [1:0]  dl_q, dl_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        moc_q, moc_d;
  logic        err_q, err_d;
  logic [31:0] data_out_q, data_out_d;

  logic [7:0]  mem_q [0:511];
  logic [8:0]  addr1, addr2, addr3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_val;
  logic        bad_req;
  logic        access;
  logic        wr_en;

  assign addr1 = addr_q + 9'd1;
  assign addr2 = addr_q + 9'd2;
  assign addr3 = addr_q + 9'd3;
  assign b0 = mem_q[addr_q];
  assign b1 = mem_q[addr1];
  assign b2 = mem_q[addr2];
  assign b3 = mem_q[addr3];

  always_comb begin
    bad_req = (dl_q == 2'b11);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    bad_req = bad_req || (dl_q == 2'b01 && addr_q[0]) || (dl_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
    // Misaligned accesses are allowed; byte addresses wrap around the 512-byte array.
    bad_req = bad_req || 1'b0;
`endif
  end

  always_comb begin
    case (dl_q)
      2'b00:   rd_val = sig_q ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   rd_val = sig_q ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: rd_val = {b0, b1, b2, b3};
    endcase
  end

  // Access happens only in the final WAIT cycle, and only if the initiator still holds mov.
  assign access = (state_q == S_WAIT) && bus.mov && (cnt_q == 4'd0);
  assign wr_en  = access && !rw_q && !bad_req;

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.mov) state_d = S_WAIT;
      S_WAIT:  if (!bus.mov) state_d = S_IDLE;
               else if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  if (!bus.mov) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    sig_d      = sig_q;
    dl_d       = dl_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    moc_d      = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mov) begin
          rw_d   = bus.rw;
          sig_d  = bus.sig;
          dl_d   = bus.dl;
          addr_d = bus.address;
          wdat_d = bus.data_in;
          cnt_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (bus.mov && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (access && rw_q && !bad_req) data_out_d = rd_val;
      end
      S_DONE: begin
        moc_d = bus.mov;
        err_d = bus.mov && bad_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      sig_q      <= 1'b0;
      dl_q       <= 2'b00;
      addr_q     <= 9'd0;
      wdat_q     <= 32'h0;
      moc_q      <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= 32'h0;
    end else begin
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      sig_q      <= sig_d;
      dl_q       <= dl_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      moc_q      <= moc_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge main_clk) begin
    if (wr_en) begin
      case (dl_q)
        2'b00: mem_q[addr_q] <= wdat_q[7:0];
        2'b01: begin
          mem_q[addr_q] <= wdat_q[15:8];
          mem_q[addr1]  <= wdat_q[7:0];
        end
        default: begin
          mem_q[addr_q] <= wdat_q[31:24];
          mem_q[addr1]  <= wdat_q[23:16];
          mem_q[addr2]  <= wdat_q[15:8];
          mem_q[addr3]  <= wdat_q[7:0];
        end
      endcase
    end
  end

  assign bus.moc      = moc_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_out_q;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
- REQ-001: Parameter WAIT_CYCLES, default 2: number of wait-state cycles (0..15) inserted before each access completes.
- REQ-002: main_clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-low reset.
- REQ-004: mov  input  1  memory operation valid; initiator holds high until moc seen.
- REQ-005: rw  input  1  1 = read, 0 = write.
- REQ-006: sig  input  1  sign-extend read data (byte/halfword only).
- REQ-007: dl  input  2  data length: 00 byte, 01 halfword, 10 word, 11 reserved.
- REQ-008: address  input  9  byte address into 512-byte big-endian array.
- REQ-009: data_in  input  32  write data, right-justified.
- REQ-010: moc  output  1  memory operation complete.
- REQ-011: data_out  output  32  read data, right-justified, registered.
- REQ-012: err  output  1  access rejected; valid while moc high.

Function
- REQ-013: FSM states IDLE, WAIT, DONE; encoding free.
- REQ-014: IDLE: mov=1 sampled -> latch rw, sig, dl, address, data_in; go WAIT with counter=WAIT_CYCLES; inputs ignored until DONE exits.
- REQ-015: WAIT: counter>0 -> decrement; counter=0 -> perform access that cycle, go DONE, moc=1 next cycle.
- REQ-016: WAIT_CYCLES=0 -> moc asserted 2 cycles after the edge sampling mov; WAIT_CYCLES=N -> N+2 cycles.
- REQ-017: DONE: moc held 1 while mov=1; mov=0 -> moc=0, err=0, return IDLE next cycle; no new request accepted in the same cycle moc falls.
- REQ-018: mov dropped during WAIT -> abort, return IDLE, no write, moc never asserted.
- REQ-019: Write: byte stores bits[7:0] at addr; halfword stores [15:8] at addr, [7:0] at addr+1; word stores [31:24]..[7:0] at addr..addr+3 (big-endian).
- REQ-020: Read: same byte order; sig=1 sign-extends byte/halfword from its MSB, sig=0 zero-extends; word ignores sig.
- REQ-021: data_out updates only on a completed, non-erroring read; otherwise holds its value.
- REQ-022: dl=11 -> err=1 with moc, no array change, data_out held.
- REQ-023: Array contents are not reset; writes occur only in the completing WAIT cycle.

Reset
- REQ-024: reset=0 asynchronously forces state IDLE, counter 0, moc=0, err=0, data_out=32'h0.
- REQ-025: Reset mid-operation aborts without writing; first request after reset release is serviced normally.

Configuration
- REQ-026: Macro MEM_RESP_ALIGN_CHECK_EN defined -> halfword with address[0]=1 or word with address[1:0]!=0 completes with err=1, no write, data_out held.
- REQ-027: MEM_RESP_ALIGN_CHECK_EN undefined -> misaligned accesses proceed; byte addresses wrap modulo 512 (word at 0x1FE uses 0x1FE, 0x1FF, 0x000, 0x001); err only for dl=11.

Verification
- REQ-028: WAIT_CYCLES=2; write word 32'hDEADBEEF at 0x010, then byte reads 0x010..0x013 -> data_out 0xDE, 0xAD, 0xBE, 0xEF; moc 4 cycles after mov sampled.
- REQ-029: Byte 0x80 at 0x020; read sig=1 -> 32'hFFFFFF80; sig=0 -> 32'h00000080; halfword 0x8001, sig=1 -> 32'hFFFF8001.
- REQ-030: mov dropped after 1 WAIT cycle of a word write to 0x040 -> moc stays 0; later word read of 0x040 returns prior contents.
- REQ-031: reset pulsed low during WAIT of a write -> moc=0, data_out=0 immediately; location unchanged.
- REQ-032: With MEM_RESP_ALIGN_CHECK_EN: word write to 0x003 -> moc=1, err=1, memory unchanged; without it: word write 0x11223344 to 0x1FE -> bytes 0x1FE=0x11, 0x1FF=0x22, 0x000=0x33, 0x001=0x44.
- REQ-033: dl=11 read -> moc=1, err=1, data_out unchanged; err returns 0 when mov drops.
